// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader_pkg : shared state encoding and framing constants for the loader
// Optional build macro: IMEM_LOADER_CHECKSUM_EN                    Rev 1.0
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int c_word_bytes = 4;
    localparam int c_hdr_bytes  = 2;
    localparam int c_state_w    = 3;

    localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_hdr0  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_hdr1  = 3'd2;
    localparam logic [c_state_w-1:0] c_st_data  = 3'd3;
    localparam logic [c_state_w-1:0] c_st_write = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [c_state_w-1:0] c_st_csum  = 3'd5;
`endif
    localparam logic [c_state_w-1:0] c_st_done  = 3'd6;
    localparam logic [c_state_w-1:0] c_st_err   = 3'd7;

    // States from which a start pulse opens a fresh session
    function automatic logic can_start(input logic [c_state_w-1:0] st);
        return (st == c_st_idle) || (st == c_st_done) || (st == c_st_err);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// word_assembler : big-endian byte-to-word shift register with byte counter
//                                                                  Rev 1.0
// ----------------------------------------------------------------------------
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      byte_en,
    input  logic [7:0]                byte_in,
    output logic [8*c_word_bytes-1:0] word,
    output logic                      last_byte
);

    localparam int c_cnt_w = $clog2(c_word_bytes);

    logic [8*c_word_bytes-1:0] r_word;
    logic [c_cnt_w-1:0]        r_cnt;

    // Counter wraps naturally after the final byte of each word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (byte_en) begin
            r_word <= {r_word[8*(c_word_bytes-1)-1:0], byte_in};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign word      = r_word;
    assign last_byte = byte_en && (r_cnt == c_cnt_w'(c_word_bytes - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader : streams a length-prefixed image into instruction memory
// Optional trailing checksum stage: IMEM_LOADER_CHECKSUM_EN        Rev 1.0
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int c_max_words = MEM_BYTES / c_word_bytes;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [c_state_w-1:0] c_st_after_data = c_st_csum;
`else
    localparam logic [c_state_w-1:0] c_st_after_data = c_st_done;
`endif

    logic [c_state_w-1:0]           r_state;
    logic [c_state_w-1:0]           w_next;
    logic [8*(c_hdr_bytes-1)-1:0]   r_hdr_hi;
    logic [15:0]                    r_words_left;
    logic [31:0]                    r_addr;
    logic [15:0]                    w_hdr_n;
    logic                           w_accept;
    logic                           w_session_start;
    logic                           w_byte_en;
    logic                           w_last_byte;
    logic [31:0]                    w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                     r_sum;
    logic [7:0]                     w_sum_final;
    assign w_sum_final = r_sum + in_data;
`endif

    assign w_accept        = in_valid && in_ready;
    assign w_session_start = start && can_start(r_state);
    assign w_byte_en       = (r_state == c_st_data) && w_accept;
    assign w_hdr_n         = {r_hdr_hi, in_data};

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_session_start),
        .byte_en   (w_byte_en),
        .byte_in   (in_data),
        .word      (w_word),
        .last_byte (w_last_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle, c_st_done, c_st_err: begin
                if (start) w_next = c_st_hdr0;
            end
            c_st_hdr0: begin
                if (w_accept) w_next = c_st_hdr1;
            end
            c_st_hdr1: begin
                if (w_accept) begin
                    if (32'(w_hdr_n) > 32'(c_max_words)) w_next = c_st_err;
                    else if (w_hdr_n == 16'd0)          w_next = c_st_after_data;
                    else                                 w_next = c_st_data;
                end
            end
            c_st_data: begin
                if (w_last_byte) w_next = c_st_write;
            end
            c_st_write: begin
                // Count still holds the word being written this cycle
                if (r_words_left == 16'd1) w_next = c_st_after_data;
                else                       w_next = c_st_data;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            c_st_csum: begin
                if (w_accept) w_next = (w_sum_final == 8'h00) ? c_st_done : c_st_err;
            end
`endif
            default: w_next = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            c_st_hdr0, c_st_hdr1, c_st_data: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            c_st_csum: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            c_st_write: begin
                busy   = 1'b1;
                mem_we = 1'b1;
            end
            c_st_done: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            c_st_err: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_hi     <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else if (w_session_start) begin
            r_hdr_hi     <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            if ((r_state == c_st_hdr0) && w_accept) r_hdr_hi <= in_data;
            if ((r_state == c_st_hdr1) && w_accept) r_words_left <= w_hdr_n;
            if (r_state == c_st_write) begin
                r_addr       <= r_addr + 32'(c_word_bytes);
                r_words_left <= r_words_left - 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_byte_en) r_sum <= r_sum + in_data;
`endif
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = w_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_loader : directed self-checking bench for imem_loader
//                                                                  Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(.MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [7:0]  stream [0:13] = '{8'h00, 8'h03, 8'hCA, 8'h0F, 8'h33, 8'h55, 8'h00,
                                   8'h33, 8'h0F, 8'hFF, 8'h20, 8'h04, 8'h00, 8'h08};
    logic [31:0] exp_word [0:2] = '{32'hCA0F3355, 32'h00330FFF, 32'h20040008};

    // Write monitor, sampled on the falling edge
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int nwr = 0;
    int rdy_viol = 0;
    int we_double = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (nwr < 64) begin
                wr_addr[nwr] = mem_addr;
                wr_data[nwr] = mem_wdata;
            end
            nwr = nwr + 1;
            if (in_ready) rdy_viol = rdy_viol + 1;
            if (prev_we) we_double = we_double + 1;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready) got = 1'b1;
            else @(negedge clk);
        end
        check("in_ready_timeout", {31'b0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] good_csum();
        logic [7:0] s = 8'h00;
        for (int i = 2; i < 14; i++) s = s + stream[i];
        return 8'h00 - s;
    endfunction

    task automatic send_stream(input int gapmax);
        for (int i = 0; i < 14; i++)
            send_byte(stream[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic wait_end(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done || error) got = 1'b1;
        end
        check(tag, {31'b0, got}, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, "_count"}, 32'(nwr - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (base + k < 64) begin
                check({tag, "_addr"}, wr_addr[base + k], 32'(4 * k));
                check({tag, "_data"}, wr_data[base + k], exp_word[k]);
            end
        end
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Nominal three-word load
        base = nwr;
        pulse_start();
        check("hdr0_busy", {31'b0, busy}, 32'd1);
        send_stream(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good_csum(), 0);
`endif
        wait_end("nominal_end");
        check("nominal_done", {31'b0, done}, 32'd1);
        check("nominal_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("nominal_busy", {31'b0, busy}, 32'd0);
        check_writes("nominal", base);

        // Same load with random valid gaps, restarted from DONE
        base = nwr;
        pulse_start();
        check("restart_done_clr", {31'b0, done}, 32'd0);
        check("restart_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        send_stream(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good_csum(), 2);
`endif
        wait_end("gaps_end");
        check("gaps_done", {31'b0, done}, 32'd1);
        check_writes("gaps", base);
        check("ready_in_write", 32'(rdy_viol), 32'd0);
        check("we_single_cycle", 32'(we_double), 32'd0);

        // Oversized header: 0x0101 words exceeds 256-word capacity
        base = nwr;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        check("big_error", {31'b0, error}, 32'd1);
        check("big_done", {31'b0, done}, 32'd0);
        check("big_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("big_no_write", 32'(nwr - base), 32'd0);

        // Reset after the second word write
        base = nwr;
        pulse_start();
        check("err_cleared", {31'b0, error}, 32'd0);
        for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
        for (int i = 0; i < 20 && nwr < base + 2; i++) @(negedge clk);
        check("mid_two_writes", 32'(nwr - base), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("mid_rst_addr", mem_addr, 32'd0);
        @(negedge clk) reset = 1'b0;
        base = nwr;
        pulse_start();
        send_stream(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good_csum(), 0);
`endif
        wait_end("reload_end");
        check("reload_done", {31'b0, done}, 32'd1);
        check_writes("reload", base);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        base = nwr;
        pulse_start();
        send_stream(0);
        send_byte(8'hCE, 0);
        wait_end("badsum_end");
        check("badsum_error", {31'b0, error}, 32'd1);
        check("badsum_done", {31'b0, done}, 32'd0);
        pulse_start();
        check("badsum_err_clr", {31'b0, error}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
`endif

        // Empty image
        base = nwr;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_end("empty_end");
        check("empty_done", {31'b0, done}, 32'd1);
        check("empty_error", {31'b0, error}, 32'd0);
        check("empty_no_write", 32'(nwr - base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
